// File: rtl/dccm_arb.sv
// Single-port DCCM arbiter between the core LSU and a DMA/loader master.
// Decodes console/finish MMIO writes and routes 1-cycle read returns to their owner.
module dccm_arb #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     STARVE_MAX   = 4,
    parameter logic [XLEN-1:0] CONSOLE_ADDR = 32'h00200000,
    parameter logic [XLEN-1:0] FINISH_ADDR  = 32'h10000000
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            lsu_req,
    input  logic            lsu_we,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [3:0]      lsu_be,
    output logic            lsu_gnt,
    output logic            lsu_rvalid,
    output logic [XLEN-1:0] lsu_rdata,

    input  logic            dma_req,
    input  logic            dma_lock,
    input  logic            dma_we,
    input  logic [XLEN-1:0] dma_addr,
    input  logic [XLEN-1:0] dma_wdata,
    input  logic [3:0]      dma_be,
    output logic            dma_gnt,
    output logic            dma_rvalid,
    output logic [XLEN-1:0] dma_rdata,

    output logic            mem_en,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            console_valid,
    output logic [7:0]      console_char,
    output logic            finish
);

    typedef enum logic {
        ARB      = 1'b0,
        DMA_LOCK = 1'b1
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e state_q, state_d;

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       lsu_rd_q, lsu_rd_d;
    logic       dma_rd_q, dma_rd_d;
    logic       mmio_rd_q, mmio_rd_d;
    logic       console_valid_q, console_valid_d;
    logic [7:0] console_char_q, console_char_d;
    logic       finish_q, finish_d;

    logic            lock_active;
    logic            starved;
    logic            any_gnt;
    logic            sel_we;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic [3:0]      sel_be;
    logic            hit_console;
    logic            hit_finish;
    logic            hit_mmio;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ARB;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:      if (dma_gnt && dma_lock) state_d = DMA_LOCK;
            DMA_LOCK: if (!dma_lock)           state_d = ARB;
            default:                           state_d = ARB;
        endcase
    end

    // ---------------- FSM: grant outputs ----------------
    // Lock only binds while dma_lock is still high; the release cycle arbitrates normally.
    always_comb begin
        lock_active = (state_q == DMA_LOCK) && dma_lock;
        starved     = (starve_cnt_q == STARVE_LIM);
        dma_gnt     = rst_n && dma_req && (lock_active || !lsu_req || starved);
        lsu_gnt     = rst_n && lsu_req && !lock_active && !dma_gnt;
    end

    // ---------------- Winner datapath and MMIO decode ----------------
    always_comb begin
        any_gnt     = lsu_gnt || dma_gnt;
        sel_we      = dma_gnt ? dma_we    : lsu_we;
        sel_addr    = dma_gnt ? dma_addr  : lsu_addr;
        sel_wdata   = dma_gnt ? dma_wdata : lsu_wdata;
        sel_be      = dma_gnt ? dma_be    : lsu_be;
        hit_console = any_gnt && (sel_addr == CONSOLE_ADDR);
        hit_finish  = any_gnt && (sel_addr == FINISH_ADDR);
        hit_mmio    = hit_console || hit_finish;

        mem_en    = any_gnt && !hit_mmio;
        mem_wen   = mem_en && sel_we;
        mem_addr  = mem_en ? sel_addr  : '0;
        mem_wdata = mem_en ? sel_wdata : '0;
        mem_be    = mem_en ? sel_be    : '0;
    end

    // ---------------- Sequential bookkeeping ----------------
    always_comb begin
        if (dma_req && !dma_gnt)
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 4'd1;
        else
            starve_cnt_d = 4'd0;

        lsu_rd_d        = lsu_gnt && !lsu_we;
        dma_rd_d        = dma_gnt && !dma_we;
        mmio_rd_d       = hit_mmio && !sel_we;
        console_valid_d = hit_console && sel_we;
        console_char_d  = console_valid_d ? sel_wdata[7:0] : 8'd0;
        finish_d        = finish_q || (hit_finish && sel_we);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q    <= 4'd0;
            lsu_rd_q        <= 1'b0;
            dma_rd_q        <= 1'b0;
            mmio_rd_q       <= 1'b0;
            console_valid_q <= 1'b0;
            console_char_q  <= 8'd0;
            finish_q        <= 1'b0;
        end else begin
            starve_cnt_q    <= starve_cnt_d;
            lsu_rd_q        <= lsu_rd_d;
            dma_rd_q        <= dma_rd_d;
            mmio_rd_q       <= mmio_rd_d;
            console_valid_q <= console_valid_d;
            console_char_q  <= console_char_d;
            finish_q        <= finish_d;
        end
    end

    // ---------------- Read return routing ----------------
    // A return is suppressed while reset is held so an in-flight read never surfaces.
    always_comb begin
        lsu_rvalid = rst_n && lsu_rd_q;
        dma_rvalid = rst_n && dma_rd_q;
        lsu_rdata  = (lsu_rvalid && !mmio_rd_q) ? mem_rdata : '0;
        dma_rdata  = (dma_rvalid && !mmio_rd_q) ? mem_rdata : '0;
    end

    assign console_valid = console_valid_q;
    assign console_char  = console_char_q;
    assign finish        = finish_q;

endmodule

// File: tb/tb_dccm_arb.sv
// Bench for dccm_arb: rule-level reference model checked every cycle under random
// traffic, plus directed scenarios with hand-computed expectations.
module tb_dccm_arb;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] CON        = 32'h00200000;
    localparam logic [31:0] FIN        = 32'h10000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_be;
    logic        dma_req, dma_lock, dma_we, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [3:0]  dma_be;
    logic        mem_en, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'd0;
    logic        console_valid, finish;
    logic [7:0]  console_char;

    always #5 clk = ~clk;

    dccm_arb dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_be(lsu_be), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_be(dma_be), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .console_valid(console_valid), .console_char(console_char), .finish(finish)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        if (i == 8'h40) return 32'hAAAA5555;
        if (i == 8'h41) return 32'h12345678;
        return {8'(i), ~8'(i), 8'(i) ^ 8'h5a, 8'hc3};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // DCCM stand-in: 256 words, 1-cycle read latency, reloaded during reset.
    logic [31:0] dccm [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) dccm[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_wen) dccm[mem_addr[9:2]] <= merge(dccm[mem_addr[9:2]], mem_wdata, mem_be);
            else         mem_rdata <= dccm[mem_addr[9:2]];
        end
    end

    // Reference model state (current and next).
    logic [31:0] shadow [256];
    bit          m_lock = 0, m_lrd = 0, m_drd = 0, m_cv = 0, m_fin = 0;
    int          m_starve = 0;
    logic [31:0] m_rdat = 0;
    logic [7:0]  m_cc = 0;
    bit          n_lock = 0, n_lrd = 0, n_drd = 0, n_cv = 0, n_fin = 0, n_wr = 0;
    int          n_starve = 0;
    logic [31:0] n_rdat = 0, n_wd = 0;
    logic [7:0]  n_cc = 0, n_wa = 0;
    logic [3:0]  n_wbe = 0;

    // Compare process: predicts this cycle's outputs from the rules, then the next state.
    always @(negedge clk) begin
        bit          eg_l, eg_d, any, we, hc, hf, mmio, men;
        logic [31:0] a, wd;
        logic [3:0]  be;
        eg_l = 0;
        eg_d = 0;
        if (rst_n) begin
            if (m_lock && dma_lock) eg_d = dma_req;
            else if (lsu_req && dma_req) begin
                if (m_starve == STARVE_MAX) eg_d = 1; else eg_l = 1;
            end else begin
                eg_l = lsu_req;
                eg_d = dma_req;
            end
        end
        any  = eg_l || eg_d;
        we   = eg_d ? dma_we    : lsu_we;
        a    = eg_d ? dma_addr  : lsu_addr;
        wd   = eg_d ? dma_wdata : lsu_wdata;
        be   = eg_d ? dma_be    : lsu_be;
        hc   = any && (a == CON);
        hf   = any && (a == FIN);
        mmio = hc || hf;
        men  = any && !mmio;

        if (chk_en) begin
            chk("lsu_gnt", lsu_gnt, eg_l);
            chk("dma_gnt", dma_gnt, eg_d);
            chk("mem_en", mem_en, men);
            if (men) begin
                chk("mem_wen", mem_wen, we);
                chk("mem_addr", mem_addr, a);
                chk("mem_wdata", mem_wdata, wd);
                chk("mem_be", mem_be, be);
            end else if (!any) begin
                chk("idle_mem_wen", mem_wen, 0);
                chk("idle_mem_addr", mem_addr, 0);
                chk("idle_mem_wdata", mem_wdata, 0);
                chk("idle_mem_be", mem_be, 0);
            end
            chk("lsu_rvalid", lsu_rvalid, rst_n && m_lrd);
            chk("lsu_rdata", lsu_rdata, (rst_n && m_lrd) ? m_rdat : 32'd0);
            chk("dma_rvalid", dma_rvalid, rst_n && m_drd);
            chk("dma_rdata", dma_rdata, (rst_n && m_drd) ? m_rdat : 32'd0);
            chk("console_valid", console_valid, m_cv);
            chk("console_char", console_char, m_cc);
            chk("finish", finish, m_fin);
        end

        if (!rst_n) begin
            n_lock = 0; n_starve = 0; n_lrd = 0; n_drd = 0; n_rdat = 0;
            n_cv = 0; n_cc = 0; n_fin = 0; n_wr = 0;
        end else begin
            n_lock   = (m_lock && dma_lock) || (eg_d && dma_lock);
            n_starve = (dma_req && !eg_d) ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
            n_lrd    = eg_l && !lsu_we;
            n_drd    = eg_d && !dma_we;
            n_rdat   = mmio ? 32'd0 : shadow[a[9:2]];
            n_cv     = hc && we;
            n_cc     = n_cv ? wd[7:0] : 8'd0;
            n_fin    = m_fin || (hf && we);
            n_wr     = men && we;
            n_wa     = a[9:2];
            n_wd     = wd;
            n_wbe    = be;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        else if (n_wr) shadow[n_wa] = merge(shadow[n_wa], n_wd, n_wbe);
        m_lock = n_lock; m_starve = n_starve; m_lrd = n_lrd; m_drd = n_drd;
        m_rdat = n_rdat; m_cv = n_cv; m_cc = n_cc; m_fin = n_fin;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lsu_req = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; lsu_be = 4'hf;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_be = 4'hf;
    endtask

    function automatic logic [31:0] raddr();
        int r;
        r = $urandom_range(0, 99);
        if (r == 0) return FIN;
        if (r < 4)  return CON;
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    task automatic rand_cycle(input bit allow_rst);
        rst_n     = allow_rst ? ($urandom_range(0, 299) != 0) : 1'b1;
        lsu_req   = $urandom_range(0, 9) < 6;
        lsu_we    = $urandom_range(0, 9) < 4;
        lsu_addr  = raddr();
        lsu_wdata = $urandom;
        lsu_be    = 4'($urandom_range(0, 15));
        dma_req   = $urandom_range(0, 9) < 5;
        dma_lock  = dma_req && ($urandom_range(0, 9) < 3);
        dma_we    = $urandom_range(0, 9) < 4;
        dma_addr  = raddr();
        dma_wdata = $urandom;
        dma_be    = 4'($urandom_range(0, 15));
        tick();
    endtask

    initial begin
        rst_n = 0;
        idle();
        tick();
        chk_en = 1;
        lsu_req = 1; dma_req = 1;
        @(negedge clk);
        chk("rst_lsu_gnt", lsu_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        tick();
        rst_n = 1;
        idle();
        @(negedge clk);
        chk("rst_finish", finish, 0);
        chk("rst_console_valid", console_valid, 0);
        tick();

        // Both read continuously: four LSU wins, then one forced DMA win.
        lsu_req = 1; lsu_addr = 32'h10;
        dma_req = 1; dma_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("starve_dma_gnt", dma_gnt, (i % 5) == 4);
            chk("starve_lsu_gnt", lsu_gnt, (i % 5) != 4);
            if (i > 0) chk("starve_lsu_rvalid", lsu_rvalid, ((i - 1) % 5) != 4);
            tick();
        end
        idle();
        tick();

        // Locked DMA burst holds off the LSU; release hands the port back at once.
        dma_req = 1; dma_lock = 1; dma_addr = 32'h30;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin lsu_req = 1; lsu_addr = 32'h34; end
            @(negedge clk);
            chk("lock_dma_gnt", dma_gnt, 1);
            chk("lock_lsu_gnt", lsu_gnt, 0);
            tick();
        end
        dma_req = 0; dma_lock = 0;
        @(negedge clk);
        chk("unlock_lsu_gnt", lsu_gnt, 1);
        tick();

        // Console write.
        idle();
        lsu_req = 1; lsu_we = 1; lsu_addr = CON; lsu_wdata = 32'h00000041;
        @(negedge clk);
        chk("con_lsu_gnt", lsu_gnt, 1);
        chk("con_mem_en", mem_en, 0);
        tick();
        idle();
        @(negedge clk);
        chk("con_valid", console_valid, 1);
        chk("con_char", console_char, 32'h41);
        tick();
        @(negedge clk);
        chk("con_valid_drop", console_valid, 0);
        tick();

        // Back-to-back reads from alternating masters.
        lsu_req = 1; lsu_addr = 32'h100;
        tick();
        idle();
        dma_req = 1; dma_addr = 32'h104;
        @(negedge clk);
        chk("b2b_lsu_rvalid", lsu_rvalid, 1);
        chk("b2b_lsu_rdata", lsu_rdata, 32'hAAAA5555);
        chk("b2b_dma_rvalid0", dma_rvalid, 0);
        tick();
        idle();
        @(negedge clk);
        chk("b2b_dma_rvalid", dma_rvalid, 1);
        chk("b2b_dma_rdata", dma_rdata, 32'h12345678);
        chk("b2b_lsu_rvalid0", lsu_rvalid, 0);
        chk("b2b_lsu_rdata0", lsu_rdata, 0);
        tick();

        // Reset while locked with a read outstanding.
        dma_req = 1; dma_lock = 1; dma_addr = 32'h104;
        tick();
        rst_n = 0;
        @(negedge clk);
        chk("rstlock_dma_rvalid", dma_rvalid, 0);
        chk("rstlock_dma_gnt", dma_gnt, 0);
        tick();
        rst_n = 1;
        lsu_req = 1; lsu_addr = 32'h8;
        @(negedge clk);
        chk("rstlock_dma_rvalid_after", dma_rvalid, 0);
        chk("rstlock_lsu_gnt", lsu_gnt, 1);
        chk("rstlock_dma_gnt_after", dma_gnt, 0);
        tick();
        idle();
        tick();

        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);

        // Finish is sticky until reset.
        rst_n = 1;
        idle();
        tick();
        dma_req = 1; dma_we = 1; dma_addr = FIN; dma_wdata = 32'd1;
        @(negedge clk);
        chk("fin_dma_gnt", dma_gnt, 1);
        chk("fin_mem_en", mem_en, 0);
        tick();
        idle();
        @(negedge clk);
        chk("fin_set", finish, 1);
        tick();
        for (int i = 0; i < 40; i++) rand_cycle(1'b0);
        idle();
        @(negedge clk);
        chk("fin_sticky", finish, 1);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("fin_cleared", finish, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dccm_arb.md
DCCM_ARB -- requirements
Module: dccm_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive lost DMA cycles before forced DMA grant, range 1..15.
REQ-003 SHALL have parameter CONSOLE_ADDR, default 32'h00200000: console MMIO byte address.
REQ-004 SHALL have parameter FINISH_ADDR, default 32'h10000000: finish MMIO byte address.
REQ-005 SHALL have ports: clk  in  1  core clock; rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have ports: lsu_req in 1, lsu_we in 1, lsu_addr in XLEN, lsu_wdata in XLEN, lsu_be in 4 -- LSU access request.
REQ-007 SHALL have ports: lsu_gnt out 1, lsu_rvalid out 1, lsu_rdata out XLEN -- LSU grant and read return.
REQ-008 SHALL have ports: dma_req in 1, dma_lock in 1, dma_we in 1, dma_addr in XLEN, dma_wdata in XLEN, dma_be in 4 -- DMA/loader request.
REQ-009 SHALL have ports: dma_gnt out 1, dma_rvalid out 1, dma_rdata out XLEN -- DMA grant and read return.
REQ-010 SHALL have ports: mem_en out 1, mem_wen out 1, mem_addr out XLEN, mem_wdata out XLEN, mem_be out 4, mem_rdata in XLEN -- single-port DCCM, 1-cycle read latency.
REQ-011 SHALL have ports: console_valid out 1, console_char out 8, finish out 1 -- MMIO side effects.

Function
REQ-012 SHALL grant combinationally in the request cycle; at most one of lsu_gnt/dma_gnt is high per cycle; gnt is never high without the matching req.
REQ-013 SHALL use FSM states ARB and DMA_LOCK; reset state ARB.
REQ-014 In ARB, LSU wins when both request, except when starve_cnt == STARVE_MAX, in which case DMA wins.
REQ-015 starve_cnt (4-bit) SHALL increment when dma_req & ~dma_gnt, saturating at STARVE_MAX, and clear on any dma_gnt or cycle without dma_req.
REQ-016 ARB -> DMA_LOCK when dma_gnt & dma_lock; in DMA_LOCK DMA gets every cycle it requests, LSU is denied; DMA_LOCK -> ARB on the first cycle dma_lock is low (that cycle arbitrates as ARB).
REQ-017 A granted access SHALL drive mem_en=1 and pass we/addr/wdata/be of the winner to mem_*, except the MMIO cases below.
REQ-018 Granted write with addr == CONSOLE_ADDR SHALL not assert mem_en; console_valid=1 and console_char=wdata[7:0] on the next cycle for one cycle.
REQ-019 Granted write with addr == FINISH_ADDR SHALL not assert mem_en; finish SHALL go high next cycle and stay high until reset.
REQ-020 MMIO reads SHALL return 0 with rvalid one cycle after grant, without asserting mem_en.
REQ-021 Read return: one cycle after a granted read, the owner's rvalid=1 with rdata=mem_rdata (or 0 for MMIO); the other rvalid=0; rdata of the non-owner is 0.
REQ-022 Back-to-back reads from alternating requesters SHALL each return on the correct port with no bubble.
REQ-023 When no grant, mem_en=mem_wen=0, mem_addr/wdata/be=0.
REQ-024 Writes produce no rvalid.

Reset
REQ-025 On rst_n=0 at clk edge: state=ARB, starve_cnt=0, rvalid owners cleared, console_valid=0, console_char=0, finish=0.
REQ-026 Reset mid-DMA_LOCK or with a read in flight SHALL drop lock and discard the pending return (no rvalid next cycle).
REQ-027 During reset, gnt outputs and mem_en SHALL be 0.

Verification
REQ-028 Both request reads continuously, STARVE_MAX=4 -> LSU granted 4 cycles, DMA granted cycle 5, pattern repeats; each rvalid one cycle after its grant.
REQ-029 DMA req+lock for 6 cycles while LSU requests -> dma_gnt 6 consecutive cycles, lsu_gnt 0; lock drops -> LSU granted same cycle.
REQ-030 LSU write 0x00000041 to 0x00200000 -> mem_en=0, next cycle console_valid=1, console_char=0x41.
REQ-031 DMA write to 0x10000000 -> finish=1 next cycle, remains 1 through further traffic until rst_n=0.
REQ-032 LSU read 0x100 then DMA read 0x104 back-to-back, mem returns 0xAAAA5555 then 0x12345678 -> lsu_rdata=0xAAAA5555, dma_rdata=0x12345678, one cycle each.
REQ-033 rst_n=0 asserted while in DMA_LOCK with a read outstanding -> next cycle no rvalid, state ARB, starve_cnt=0.
